rsa_modexp_core: RTL and testbench
==================================

// Module: rsa_modexp_core
// PURPOSE
//  Parametrised byte-serial RSA modular-exponentiation engine: dout = base^exp mod mod.
//  Successor to the 8-bit rsa_core; operands generalised to WIDTH bits, with operand-range error checking.
//  Sits behind the same byte-load host interface; optional constant-time mode.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; multiple of 8, range 8..64
//  NBYTES  WIDTH/8  bytes per operand (derived, localparam)
// PORTS
//  core_clk   in   1      system clock, rising edge
//  core_rst   in   1      reset, asynchronous, active-low
//  core_load  in   1      active-low byte strobe; each cycle sampled low = one byte
//  core_din   in   8      load byte
//  core_done  out  1      result valid; held high until next load or reset
//  core_err   out  1      operand error; valid only while core_done=1
//  core_dout  out  WIDTH  result; 0 when core_err=1
// BEHAVIOUR
//  Reset (core_rst=0, async): state IDLE, byte count 0, core_done=0, core_err=0, core_dout=0.
//  Load order: base, exponent, modulus; NBYTES each, MSB byte first; 3*NBYTES bytes total.
//  FSM: IDLE -> LOAD (first byte) -> CHECK (1 cycle after final byte) -> SQR/MUL loop -> DONE.
//  CHECK: err if mod<2 or base>=mod -> DONE with core_err=1, core_dout=0, next cycle.
//  Exponentiation: left-to-right over all WIDTH exponent bits, MSB first, including leading zeros.
//    R starts at 1. Per bit: SQR (R=R*R mod m), then MUL (R=R*base mod m) only if bit=1.
//  Modmul: interleaved shift-add (Blakley), exactly WIDTH cycles, one multiplier bit per cycle.
//    Per step: P=2P+(b?A:0), then subtract m up to twice. Intermediate width WIDTH+2; never overflows.
//  DONE: core_done=1, core_dout=R. Both hold until the next core_load low.
//  core_load low in DONE: core_done/core_err clear on that edge; byte taken as byte 0 of a new triple.
//  core_load low during CHECK/SQR/MUL: computation aborted; byte taken as byte 0 of a new triple; no done.
//  Exponent 0: result 1 (mod>=2). Base 0, exp>0: result 0.
//  Reset mid-operation: immediate return to reset values; partial operands discarded.
// CONFIGURATION
//  RSA_CONST_TIME_EN defined: MUL executes for every exponent bit.
//    Product is discarded when bit=0. core_done rises exactly 2*WIDTH*WIDTH+2 cycles after
//    the edge sampling the final byte (130 for WIDTH=8). Error exit is also delayed to that cycle.
//  Undefined: MUL skipped on 0 bits; latency data-dependent,
//    WIDTH*WIDTH+2 .. 2*WIDTH*WIDTH+2 cycles; error exit 2 cycles.
// STRUCTURE
//  rsa_pkg: FSM state localparams (IDLE, LOAD, CHECK, SQR, MUL, DONE) and width/byte-count helpers.
//  Sub-module rsa_modmul #(WIDTH): start/busy/done handshake; inputs a, b, m; output p = a*b mod m.
//    Top FSM sequences rsa_modmul and holds R/base/exp/mod registers.
// TESTING
//  T1 WIDTH=8: load 04,0D,1F -> core_done=1, core_err=0, core_dout=02.
//  T2 WIDTH=8: load 07,00,0D -> core_dout=01. load 00,05,0D -> core_dout=00.
//  T3 WIDTH=8: load 05,03,00 -> core_err=1, core_dout=00.
//     load 20,03,11 -> core_err=1 (base>=mod). Both checks apply without the macro.
//  T4 WIDTH=16: load 00,04,00,0D,01,F1 -> core_dout=01BD (445). With RSA_CONST_TIME_EN,
//     done at exactly 514 cycles after the last byte; done falls on the next load.
//  T5 Abort: WIDTH=8, start 04,0D,1F; pulse core_load with 09 mid-SQR; then load 02,1F
//     -> no done for the aborted run; result 09^02 mod 1F = 13 (0x13, i.e. 81 mod 31 = 19).
//  T6 Reset: assert core_rst mid-computation -> all outputs 0 asynchronously;
//     after release, a fresh T1 triple passes.

Source files
------------

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the byte-serial RSA modular-exponentiation engine:
// the FSM state encoding of rsa_modexp_core and small width/byte-count
// helpers used to size counters in rsa_modexp_core and rsa_modmul.
// No ports (package).
// ---------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SQR   = 3'd3,
    ST_MUL   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  // Number of load bytes that make up one operand.
  function automatic int bytes_per_operand(input int width);
    return width / 8;
  endfunction

  // Width of a counter that indexes the bits of a width-bit operand.
  function automatic int bit_index_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// ---------------------------------------------------------------------------
// rsa_modmul
// Interleaved shift-add (Blakley) modular multiplier: p = a*b mod m.
// One multiplier bit per cycle, MSB first, exactly WIDTH cycles per product.
// The first step is performed on the edge that samples start, so a product
// started on edge S is complete after edge S+WIDTH-1 and done pulses in the
// following cycle. a, b and m are not captured: the caller holds them stable
// while busy. A start while busy restarts the multiplier.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a new product (first step on this edge)
//   a, b, m      multiplicand, multiplier, modulus (a < m for exact results)
//   busy         product in progress
//   done         one-cycle pulse, p valid while high and until next start
//   p            product register
// ---------------------------------------------------------------------------
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int IW = bit_index_width(WIDTH);
  localparam logic [IW-1:0] TOP_BIT    = IW'(WIDTH - 1);
  localparam logic [IW-1:0] SECOND_BIT = IW'(WIDTH - 2);
  localparam logic [IW-1:0] CNT_ONE    = IW'(1);
  localparam logic [IW-1:0] CNT_ZERO   = IW'(0);

  logic [WIDTH-1:0] p_q, p_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IW-1:0]    idx_s;
  logic             mbit_s;
  logic [WIDTH-1:0] p_cur_s;
  logic [WIDTH+1:0] m_ext_s;
  logic [WIDTH+1:0] acc_s;
  logic [WIDTH+1:0] red1_s;
  logic [WIDTH-1:0] p_step_s;

  // One Blakley step: P = 2P + (bit ? A : 0), then up to two subtractions of m.
  // With P, A < m the sum is below 3m, which fits in WIDTH+2 bits.
  always_comb begin
    if (start) begin
      idx_s   = TOP_BIT;
      p_cur_s = {WIDTH{1'b0}};
    end else begin
      idx_s   = cnt_q;
      p_cur_s = p_q;
    end
    mbit_s  = b[idx_s];
    m_ext_s = {2'b00, m};
    if (mbit_s) begin
      acc_s = {1'b0, p_cur_s, 1'b0} + {2'b00, a};
    end else begin
      acc_s = {1'b0, p_cur_s, 1'b0};
    end
    if (acc_s >= m_ext_s) begin
      red1_s = acc_s - m_ext_s;
    end else begin
      red1_s = acc_s;
    end
    if (red1_s >= m_ext_s) begin
      p_step_s = WIDTH'(red1_s - m_ext_s);
    end else begin
      p_step_s = WIDTH'(red1_s);
    end
  end

  // Step sequencing: cnt_q is the multiplier bit used by the next step.
  always_comb begin
    p_d    = p_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      p_d    = p_step_s;
      cnt_d  = SECOND_BIT;
      busy_d = 1'b1;
    end else if (busy_q) begin
      p_d = p_step_s;
      if (cnt_q == CNT_ZERO) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      p_d = p_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= {WIDTH{1'b0}};
      cnt_q  <= CNT_ZERO;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/rsa_modexp_core.sv
// ---------------------------------------------------------------------------
// rsa_modexp_core
// Byte-serial RSA modular exponentiation: core_dout = base^exp mod mod.
// Operands are WIDTH bits (multiple of 8, 8..64), loaded MSB byte first in
// the order base, exponent, modulus. Left-to-right square-and-multiply over
// all WIDTH exponent bits, using rsa_modmul for every product.
// Optional macro RSA_CONST_TIME_EN: a multiply is executed for every exponent
// bit (product discarded on 0 bits) and the operand-error exit waits for the
// same fixed latency, so done always rises 2*WIDTH*WIDTH+2 cycles after the
// final byte. Without it, 0 bits skip the multiply and errors exit at once.
// Ports:
//   core_clk    clock, rising edge
//   core_rst    asynchronous active-low reset
//   core_load   active-low byte strobe, one byte per cycle sampled low
//   core_din    load byte
//   core_done   result valid, held until the next byte or reset
//   core_err    operand error (mod < 2 or base >= mod), valid with core_done
//   core_dout   result, 0 when core_err is set
// ---------------------------------------------------------------------------
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             core_load,
  input  logic [7:0]       core_din,
  output logic             core_done,
  output logic             core_err,
  output logic [WIDTH-1:0] core_dout
);

  localparam int NBYTES = bytes_per_operand(WIDTH);
  localparam int NLOAD  = 3 * NBYTES;
  localparam int CW     = $clog2(NLOAD);
  localparam int IW     = bit_index_width(WIDTH);
  localparam int OW     = 3 * WIDTH;
  localparam logic [CW-1:0]    LAST_BYTE = CW'(NLOAD - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [IW-1:0]    TOP_BIT   = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    BIT_ONE   = IW'(1);
  localparam logic [IW-1:0]    BIT_ZERO  = IW'(0);
  localparam logic [WIDTH-1:0] R_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOD_MIN   = WIDTH'(2);
`ifdef RSA_CONST_TIME_EN
  localparam logic CONST_TIME = 1'b1;
`else
  localparam logic CONST_TIME = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [OW-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic             err_flag_q, err_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             byte_s, op_done_s, opnd_bad_s, exp_bit_s, last_bit_s;
  logic             mm_start_s, mm_busy_s, mm_done_s;
  logic [WIDTH-1:0] base_s, exp_s, mod_s, mm_a_s, mm_b_s, mm_p_s;

  assign byte_s     = ~core_load;
  assign base_s     = opnd_q[OW-1 -: WIDTH];
  assign exp_s      = opnd_q[2*WIDTH-1 -: WIDTH];
  assign mod_s      = opnd_q[WIDTH-1:0];
  assign opnd_bad_s = (mod_s < MOD_MIN) || (base_s >= mod_s);
  assign exp_bit_s  = exp_s[bit_q];
  assign last_bit_s = (bit_q == BIT_ZERO);
  assign op_done_s  = mm_done_s & ~mm_busy_s;

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (core_clk),
    .rst_n (core_rst),
    .start (mm_start_s),
    .a     (mm_a_s),
    .b     (mm_b_s),
    .m     (mod_s),
    .busy  (mm_busy_s),
    .done  (mm_done_s),
    .p     (mm_p_s)
  );

  // FSM state register.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a byte strobe always wins and (re)starts loading, which is
  // also how a running computation or a held result is abandoned.
  always_comb begin
    state_d = state_q;
    if (byte_s) begin
      if ((state_q == ST_LOAD) && (bcnt_q == LAST_BYTE)) begin
        state_d = ST_CHECK;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (CONST_TIME || !opnd_bad_s) begin
            state_d = ST_SQR;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_SQR: begin
          if (!op_done_s) begin
            state_d = ST_SQR;
          end else if (CONST_TIME || exp_bit_s) begin
            state_d = ST_MUL;
          end else if (last_bit_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SQR;
          end
        end
        ST_MUL: begin
          if (!op_done_s) begin
            state_d = ST_MUL;
          end else if (last_bit_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SQR;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: accumulator/bit-index updates and multiplier control.
  // The next product starts on the same edge the previous one is written
  // back, so its operands are forwarded from r_d rather than r_q.
  always_comb begin
    r_d        = r_q;
    bit_d      = bit_q;
    err_flag_d = err_flag_q;
    if (byte_s) begin
      err_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          r_d        = R_ONE;
          bit_d      = TOP_BIT;
          err_flag_d = opnd_bad_s;
        end
        ST_SQR, ST_MUL: begin
          if (op_done_s) begin
            // A multiply on a 0 bit (constant-time only) is discarded.
            if ((state_q == ST_SQR) || exp_bit_s) begin
              r_d = mm_p_s;
            end else begin
              r_d = r_q;
            end
            if (state_d == ST_SQR) begin
              bit_d = bit_q - BIT_ONE;
            end else begin
              bit_d = bit_q;
            end
          end else begin
            r_d = r_q;
          end
        end
        default: r_d = r_q;
      endcase
    end
    mm_start_s = ((state_q == ST_CHECK) || op_done_s) &&
                 ((state_d == ST_SQR) || (state_d == ST_MUL));
    mm_a_s = r_d;
    if (state_d == ST_MUL) begin
      mm_b_s = base_s;
    end else begin
      mm_b_s = r_d;
    end
  end

  // Byte counter and operand shift register (base ends up in the top bytes).
  always_comb begin
    if (byte_s) begin
      opnd_d = {opnd_q[OW-9:0], core_din};
      if (state_q != ST_LOAD) begin
        bcnt_d = CNT_ONE;
      end else if (bcnt_q == LAST_BYTE) begin
        bcnt_d = CNT_ZERO;
      end else begin
        bcnt_d = bcnt_q + CNT_ONE;
      end
    end else begin
      opnd_d = opnd_q;
      bcnt_d = bcnt_q;
    end
  end

  // Result outputs: registered from the DONE state, dropped on a new byte.
  always_comb begin
    done_d = (state_q == ST_DONE) && !byte_s;
    if (done_d) begin
      err_d = err_flag_q;
      if (err_flag_q) begin
        dout_d = {WIDTH{1'b0}};
      end else begin
        dout_d = r_q;
      end
    end else begin
      err_d  = 1'b0;
      dout_d = {WIDTH{1'b0}};
    end
  end

  // Datapath and output registers.
  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      bcnt_q     <= CNT_ZERO;
      opnd_q     <= {OW{1'b0}};
      r_q        <= {WIDTH{1'b0}};
      bit_q      <= BIT_ZERO;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= {WIDTH{1'b0}};
    end else begin
      bcnt_q     <= bcnt_d;
      opnd_q     <= opnd_d;
      r_q        <= r_d;
      bit_q      <= bit_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  assign core_done = done_q;
  assign core_err  = err_q;
  assign core_dout = dout_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// ---------------------------------------------------------------------------
// tb_rsa_modexp_core
// Directed bench for rsa_modexp_core: an 8-bit instance driven from a vector
// table (result, error flag and done latency per triple) plus hand-written
// sequences for done hold/clear, abort, reset and a 16-bit instance.
// Latency is counted in clock edges from the edge that samples the final
// byte to the edge after which core_done is seen high.
// ---------------------------------------------------------------------------
module tb_rsa_modexp_core;

`ifdef RSA_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int LAT8_CT  = 130;
  localparam int LAT16_CT = 514;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load8 = 1'b1;
  logic        load16 = 1'b1;
  logic [7:0]  din8 = 8'h00;
  logic [7:0]  din16 = 8'h00;
  logic        done8, err8, done16, err16;
  logic [7:0]  dout8;
  logic [15:0] dout16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rsa_modexp_core #(.WIDTH(8)) dut8 (
    .core_clk  (clk),
    .core_rst  (rst_n),
    .core_load (load8),
    .core_din  (din8),
    .core_done (done8),
    .core_err  (err8),
    .core_dout (dout8)
  );

  rsa_modexp_core #(.WIDTH(16)) dut16 (
    .core_clk  (clk),
    .core_rst  (rst_n),
    .core_load (load16),
    .core_din  (din16),
    .core_done (done16),
    .core_err  (err16),
    .core_dout (dout16)
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] expn;
    logic [7:0] modv;
    logic [7:0] res;
    logic       err;
    int         lat;   // latency without constant-time mode
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input bit w16, input logic [7:0] b);
    @(negedge clk);
    if (w16) begin
      load16 = 1'b0;
      din16  = b;
    end else begin
      load8 = 1'b0;
      din8  = b;
    end
  endtask

  task automatic release_load();
    @(negedge clk);
    load8  = 1'b1;
    load16 = 1'b1;
  endtask

  // Counts edges after the final-byte edge until done is seen (bounded).
  task automatic wait_done(input bit w16, output int lat);
    logic d;
    lat = 0;
    d = 1'b0;
    while (!d && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      d = w16 ? done16 : done8;
    end
  endtask

  task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                      output int lat);
    send(1'b0, b);
    send(1'b0, e);
    send(1'b0, m);
    release_load();
    wait_done(1'b0, lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_lat;

    vecs[0]  = '{8'h04, 8'h0D, 8'h1F, 8'h02, 1'b0, 90};
    vecs[1]  = '{8'h07, 8'h00, 8'h0D, 8'h01, 1'b0, 66};
    vecs[2]  = '{8'h00, 8'h05, 8'h0D, 8'h00, 1'b0, 82};
    vecs[3]  = '{8'h05, 8'h03, 8'h00, 8'h00, 1'b1, 2};
    vecs[4]  = '{8'h20, 8'h03, 8'h11, 8'h00, 1'b1, 2};
    vecs[5]  = '{8'h0C, 8'h01, 8'h01, 8'h00, 1'b1, 2};
    vecs[6]  = '{8'h1F, 8'h01, 8'h1F, 8'h00, 1'b1, 2};
    vecs[7]  = '{8'h1E, 8'hFF, 8'h1F, 8'h1E, 1'b0, 130};
    vecs[8]  = '{8'h02, 8'h0A, 8'hFF, 8'h04, 1'b0, 82};
    vecs[9]  = '{8'h01, 8'h07, 8'h02, 8'h01, 1'b0, 90};
    vecs[10] = '{8'h00, 8'h00, 8'h02, 8'h01, 1'b0, 66};
    vecs[11] = '{8'h03, 8'h05, 8'hFB, 8'hF3, 1'b0, 82};
    vecs[12] = '{8'hFA, 8'h02, 8'hFB, 8'h01, 1'b0, 74};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset done8", {63'd0, done8}, 64'd0);
    check("reset err8", {63'd0, err8}, 64'd0);
    check("reset dout8", {56'd0, dout8}, 64'd0);
    check("reset done16", {63'd0, done16}, 64'd0);
    check("reset dout16", {48'd0, dout16}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, 8-bit instance
    for (int i = 0; i < 13; i++) begin
      run8(vecs[i].base, vecs[i].expn, vecs[i].modv, lat);
      exp_lat = CT ? LAT8_CT : vecs[i].lat;
      check($sformatf("v%0d done", i), {63'd0, done8}, 64'd1);
      check($sformatf("v%0d err", i), {63'd0, err8}, {63'd0, vecs[i].err});
      check($sformatf("v%0d dout", i), {56'd0, dout8}, {56'd0, vecs[i].res});
      check($sformatf("v%0d latency", i), lat, exp_lat);
    end

    // Result holds, then clears on the edge that takes the next byte
    repeat (4) @(posedge clk);
    #1;
    check("hold done", {63'd0, done8}, 64'd1);
    check("hold dout", {56'd0, dout8}, 64'h01);
    send(1'b0, 8'h04);
    @(posedge clk);
    #1;
    check("clear done", {63'd0, done8}, 64'd0);
    check("clear dout", {56'd0, dout8}, 64'd0);
    send(1'b0, 8'h0D);
    send(1'b0, 8'h1F);
    release_load();
    wait_done(1'b0, lat);
    check("reload dout", {56'd0, dout8}, 64'h02);
    check("reload latency", lat, CT ? LAT8_CT : 90);

    // Error result clears on the next byte as well
    run8(8'h05, 8'h03, 8'h00, lat);
    check("err set", {63'd0, err8}, 64'd1);
    send(1'b0, 8'h04);
    @(posedge clk);
    #1;
    check("err clear", {63'd0, err8}, 64'd0);
    send(1'b0, 8'h0D);
    send(1'b0, 8'h1F);
    release_load();
    wait_done(1'b0, lat);

    // Abort mid-SQR: the interrupting byte starts a new triple 09,02,1F
    send(1'b0, 8'h04);
    send(1'b0, 8'h0D);
    send(1'b0, 8'h1F);
    release_load();
    repeat (5) @(posedge clk);
    send(1'b0, 8'h09);
    release_load();
    check("abort no done", {63'd0, done8}, 64'd0);
    send(1'b0, 8'h02);
    send(1'b0, 8'h1F);
    release_load();
    wait_done(1'b0, lat);
    check("abort dout", {56'd0, dout8}, 64'h13);
    check("abort latency", lat, CT ? LAT8_CT : 74);

    // Asynchronous reset while a result is held
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst done", {63'd0, done8}, 64'd0);
    check("async rst dout", {56'd0, dout8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-computation, then reset after a partial load
    send(1'b0, 8'h04);
    send(1'b0, 8'h0D);
    send(1'b0, 8'h1F);
    release_load();
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h07);
    release_load();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h04, 8'h0D, 8'h1F, lat);
    check("post-rst dout", {56'd0, dout8}, 64'h02);
    check("post-rst latency", lat, CT ? LAT8_CT : 90);

    // 16-bit instance: 0x0004^0x000D mod 0x01F1 = 0x01BD
    send(1'b1, 8'h00);
    send(1'b1, 8'h04);
    send(1'b1, 8'h00);
    send(1'b1, 8'h0D);
    send(1'b1, 8'h01);
    send(1'b1, 8'hF1);
    release_load();
    wait_done(1'b1, lat);
    check("w16 done", {63'd0, done16}, 64'd1);
    check("w16 err", {63'd0, err16}, 64'd0);
    check("w16 dout", {48'd0, dout16}, 64'h01BD);
    check("w16 latency", lat, CT ? LAT16_CT : 306);

    // 16-bit base == mod error; also checks done falls on the first byte
    send(1'b1, 8'h01);
    @(posedge clk);
    #1;
    check("w16 clear done", {63'd0, done16}, 64'd0);
    send(1'b1, 8'hF1);
    send(1'b1, 8'h00);
    send(1'b1, 8'h01);
    send(1'b1, 8'h01);
    send(1'b1, 8'hF1);
    release_load();
    wait_done(1'b1, lat);
    check("w16 err set", {63'd0, err16}, 64'd1);
    check("w16 err dout", {48'd0, dout16}, 64'd0);
    check("w16 err latency", lat, CT ? LAT16_CT : 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
